// File: rtl/mesi_coherence_ctrl.sv
// rtl/mesi_coherence_ctrl.sv - MESI snoop/coherence controller for NUM_CORES direct-mapped L1 caches
module mesi_coherence_ctrl #(
  parameter int NUM_CORES     = 4,
  parameter int L1_ADDR_WIDTH = 2,
  parameter int L2_ADDR_WIDTH = 3,
  localparam int CW           = $clog2(NUM_CORES)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CORES-1:0]               req_valid,
  input  logic [NUM_CORES-1:0]               req_we,
  input  logic [NUM_CORES*L2_ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_CORES-1:0]               done,
  output logic                               hit,
  output logic [NUM_CORES-1:0]               inv_mask,
  output logic [CW-1:0]                      wb_core,
  output logic [CW-1:0]                      fill_core,
  output logic                               l2_rd_en,
  output logic                               l2_wr_en,
  output logic [L2_ADDR_WIDTH-1:0]           l2_addr,
  input  logic                               l2_ack,
  input  logic [CW-1:0]                      dbg_core,
  input  logic [L1_ADDR_WIDTH-1:0]           dbg_index,
  output logic [1:0]                         dbg_state
);

  localparam int LINES = 1 << L1_ADDR_WIDTH;
  localparam int TW    = L2_ADDR_WIDTH - L1_ADDR_WIDTH;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  typedef enum logic [2:0] {IDLE, LOOKUP, VICTIM_WB, SNOOP_WB, FILL, DONE} fsm_t;

  fsm_t state_q, state_d;

  logic [1:0]    line_state [NUM_CORES][LINES];
  logic [TW-1:0] line_tag   [NUM_CORES][LINES];

  logic [CW-1:0]            ptr_q;
  logic [CW-1:0]            core_q;
  logic                     we_q;
  logic [L2_ADDR_WIDTH-1:0] addr_q;
  logic                     hit_q;

  logic [L1_ADDR_WIDTH-1:0] idx;
  logic [TW-1:0]            tag;
  logic [1:0]               local_state;
  logic                     local_hit;

  assign idx         = addr_q[L1_ADDR_WIDTH-1:0];
  assign tag         = addr_q[L2_ADDR_WIDTH-1:L1_ADDR_WIDTH];
  assign local_state = line_state[core_q][idx];
  assign local_hit   = (local_state != ST_I) && (line_tag[core_q][idx] == tag);
  assign dbg_state   = line_state[dbg_core][dbg_index];

  // Round-robin grant: rotate requests so the pointer sits at bit 0, take the lowest set bit
  logic [2*NUM_CORES-1:0]   req_dbl;
  logic [NUM_CORES-1:0]     req_rot;
  logic [CW:0]              grant_off;
  logic [CW:0]              grant_sum;
  logic [CW-1:0]            grant;
  logic                     grant_valid;
  logic                     sel_we;
  logic [L2_ADDR_WIDTH-1:0] sel_addr;

  assign req_dbl = {req_valid, req_valid};
  assign req_rot = req_dbl[ptr_q +: NUM_CORES];

  // Pick the granted core and mux out its write flag and address
  always_comb begin
    grant_off   = '0;
    grant_valid = 1'b0;
    grant       = '0;
    sel_we      = 1'b0;
    sel_addr    = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_off   = (CW+1)'(k);
        grant_valid = 1'b1;
      end
    end
    grant_sum = {1'b0, ptr_q} + grant_off;
    if (grant_sum >= (CW+1)'(NUM_CORES)) grant = CW'(grant_sum - (CW+1)'(NUM_CORES));
    else                                 grant = CW'(grant_sum);
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant == CW'(i)) begin
        sel_we   = req_we[i];
        sel_addr = req_addr[i*L2_ADDR_WIDTH +: L2_ADDR_WIDTH];
      end
    end
  end

  // Snoop the other cores: valid copies of the requested line and a possible M owner
  logic [NUM_CORES-1:0] match_vec;
  logic                 owner_found;
  logic [CW-1:0]        owner;

  always_comb begin
    match_vec   = '0;
    owner_found = 1'b0;
    owner       = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (CW'(i) != core_q && line_state[i][idx] != ST_I && line_tag[i][idx] == tag) begin
        match_vec[i] = 1'b1;
        if (line_state[i][idx] == ST_M) begin
          owner_found = 1'b1;
          owner       = CW'(i);
        end
      end
    end
  end

  // Next-state and output decode; outputs are a function of the current state only, except
  // the inv_mask pulse that accompanies a write fill's ack
  always_comb begin
    state_d   = state_q;
    done      = '0;
    hit       = 1'b0;
    inv_mask  = '0;
    wb_core   = '0;
    fill_core = '0;
    l2_rd_en  = 1'b0;
    l2_wr_en  = 1'b0;
    l2_addr   = '0;
    case (state_q)
      IDLE: begin
        if (grant_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (local_hit) begin
          state_d = DONE;
          if (we_q && local_state == ST_S) inv_mask = match_vec;
        end else if (local_state == ST_M) begin
          state_d = VICTIM_WB;
        end else begin
          state_d = owner_found ? SNOOP_WB : FILL;
        end
      end
      VICTIM_WB: begin
        l2_wr_en = 1'b1;
        l2_addr  = {line_tag[core_q][idx], idx};
        wb_core  = core_q;
        if (l2_ack) state_d = owner_found ? SNOOP_WB : FILL;
      end
      SNOOP_WB: begin
        l2_wr_en = 1'b1;
        l2_addr  = addr_q;
        wb_core  = owner;
        if (l2_ack) state_d = FILL;
      end
      FILL: begin
        l2_rd_en  = 1'b1;
        l2_addr   = addr_q;
        fill_core = core_q;
        if (l2_ack) begin
          state_d = DONE;
          if (we_q) inv_mask = match_vec;
        end
      end
      DONE: begin
        done[core_q] = 1'b1;
        hit          = hit_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, request latch and per-line MESI/tag updates
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      core_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      hit_q   <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        for (int j = 0; j < LINES; j++) begin
          line_state[i][j] <= ST_I;
          line_tag[i][j]   <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            core_q <= grant;
            we_q   <= sel_we;
            addr_q <= sel_addr;
            ptr_q  <= (grant == CW'(NUM_CORES - 1)) ? '0 : grant + 1'b1;
          end
        end
        LOOKUP: begin
          hit_q <= local_hit;
          if (local_hit && we_q) begin
            line_state[core_q][idx] <= ST_M;
            if (local_state == ST_S) begin
              for (int i = 0; i < NUM_CORES; i++)
                if (match_vec[i]) line_state[i][idx] <= ST_I;
            end
          end
        end
        VICTIM_WB: begin
          if (l2_ack) line_state[core_q][idx] <= ST_I;
        end
        SNOOP_WB: begin
          if (l2_ack) line_state[owner][idx] <= we_q ? ST_I : ST_S;
        end
        FILL: begin
          if (l2_ack) begin
            line_tag[core_q][idx] <= tag;
            if (we_q) begin
              line_state[core_q][idx] <= ST_M;
              for (int i = 0; i < NUM_CORES; i++)
                if (match_vec[i]) line_state[i][idx] <= ST_I;
            end else if (|match_vec) begin
              line_state[core_q][idx] <= ST_S;
              for (int i = 0; i < NUM_CORES; i++)
                if (match_vec[i]) line_state[i][idx] <= ST_S;
            end else begin
              line_state[core_q][idx] <= ST_E;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_coherence_ctrl.sv
// tb/tb_mesi_coherence_ctrl.sv - self-checking bench for mesi_coherence_ctrl against a transaction-level MESI model
module tb_mesi_coherence_ctrl;
  localparam int N  = 4;
  localparam int L1 = 2;
  localparam int L2 = 3;
  localparam int LINES = 1 << L1;
  localparam int I_ = 0, S_ = 1, E_ = 2, M_ = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_we;
  logic [N*L2-1:0] req_addr;
  logic [N-1:0]    done, inv_mask;
  logic            hit, l2_rd_en, l2_wr_en, l2_ack;
  logic [1:0]      wb_core, fill_core, dbg_core, dbg_state;
  logic [L2-1:0]   l2_addr;
  logic [L1-1:0]   dbg_index;

  mesi_coherence_ctrl #(.NUM_CORES(N), .L1_ADDR_WIDTH(L1), .L2_ADDR_WIDTH(L2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .done(done), .hit(hit), .inv_mask(inv_mask), .wb_core(wb_core), .fill_core(fill_core),
    .l2_rd_en(l2_rd_en), .l2_wr_en(l2_wr_en), .l2_addr(l2_addr), .l2_ack(l2_ack),
    .dbg_core(dbg_core), .dbg_index(dbg_index), .dbg_state(dbg_state)
  );

  always #10 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model: per-core per-line state/tag, round-robin pointer, pending requests
  int mst [N][LINES];
  int mtg [N][LINES];
  int mptr;
  bit pv [N];
  bit pwe [N];
  int pad [N];

  // expectations and observations of the current transaction; ops encoded wr*256+addr*16+core
  int exp_ops [$];
  int obs_ops [$];
  int exp_inv, obs_inv, obs_done;
  bit exp_hit, obs_hit;

  // L2 responder state
  int ack_cnt;
  int cap_op;

  function automatic int enc(input int wr, input int a, input int c);
    return wr * 256 + a * 16 + c;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++)
      for (int i = 0; i < LINES; i++) begin
        mst[c][i] = I_;
        mtg[c][i] = 0;
      end
    mptr = 0;
  endtask

  // what one request must do, derived from the coherence rules on the model arrays
  task automatic model_txn(input int c, input bit we, input int a);
    int idx, tg, own;
    bit shared;
    idx = a % LINES;
    tg  = a / LINES;
    exp_ops.delete();
    exp_inv = 0;
    if (mst[c][idx] != I_ && mtg[c][idx] == tg) begin
      exp_hit = 1;
      if (we) begin
        if (mst[c][idx] == S_)
          for (int o = 0; o < N; o++)
            if (o != c && mst[o][idx] != I_ && mtg[o][idx] == tg) begin
              exp_inv |= (1 << o);
              mst[o][idx] = I_;
            end
        mst[c][idx] = M_;
      end
    end else begin
      exp_hit = 0;
      if (mst[c][idx] == M_) begin
        exp_ops.push_back(enc(1, mtg[c][idx] * LINES + idx, c));
        mst[c][idx] = I_;
      end
      own = -1;
      for (int o = 0; o < N; o++)
        if (o != c && mst[o][idx] == M_ && mtg[o][idx] == tg) own = o;
      if (own >= 0) begin
        exp_ops.push_back(enc(1, a, own));
        mst[own][idx] = we ? I_ : S_;
      end
      exp_ops.push_back(enc(0, a, c));
      shared = 0;
      for (int o = 0; o < N; o++)
        if (o != c && mst[o][idx] != I_ && mtg[o][idx] == tg) begin
          if (we) begin
            exp_inv |= (1 << o);
            mst[o][idx] = I_;
          end else begin
            mst[o][idx] = S_;
            shared = 1;
          end
        end
      mst[c][idx] = we ? M_ : (shared ? S_ : E_);
      mtg[c][idx] = tg;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pv[i];
      req_we[i]    = pwe[i];
      req_addr[i*L2 +: L2] = L2'(pad[i]);
    end
  endtask

  task automatic sweep(input string tag);
    for (int c = 0; c < N; c++)
      for (int i = 0; i < LINES; i++) begin
        dbg_core  = 2'(c);
        dbg_index = L1'(i);
        #1;
        check($sformatf("%s_dbg_c%0d_i%0d", tag, c, i), dbg_state, mst[c][i]);
      end
  endtask

  function automatic int dbg_read(input int c, input int i);
    return mst[c][i];
  endfunction

  task automatic dbg_lit(input string name, input int c, input int i, input int exp);
    dbg_core  = 2'(c);
    dbg_index = L1'(i);
    #1;
    check(name, dbg_state, exp);
  endtask

  // serve the next request: predict the grant, run cycles as L2 responder, compare, retire
  task automatic serve(input bit lat_chk);
    int c, cyc, cur_op;
    bit got, en;
    c = -1;
    for (int k = 0; k < N; k++)
      if (c < 0 && pv[(mptr + k) % N]) c = (mptr + k) % N;
    if (c < 0) return;
    model_txn(c, pwe[c], pad[c]);
    mptr = (c + 1) % N;
    obs_inv = 0;
    obs_ops.delete();
    obs_done = 0;
    obs_hit = 0;
    cyc = 0;
    got = 0;
    while (!got && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (done != 0) begin
        got = 1;
        obs_done = int'(done);
        obs_hit  = hit;
      end else begin
        en = l2_rd_en | l2_wr_en;
        cur_op = l2_wr_en ? enc(1, int'(l2_addr), int'(wb_core)) : enc(0, int'(l2_addr), int'(fill_core));
        if (en) check("l2_rd_wr_exclusive", int'(l2_rd_en & l2_wr_en), 0);
        if (l2_ack) begin
          l2_ack  = 1'b0;
          ack_cnt = en ? 1 : 0;
          cap_op  = cur_op;
        end else if (en) begin
          if (ack_cnt == 0) begin
            ack_cnt = 1;
            cap_op  = cur_op;
          end else begin
            check("l2_req_stable", cur_op, cap_op);
            obs_ops.push_back(cur_op);
            l2_ack = 1'b1;
          end
        end else begin
          ack_cnt = 0;
        end
        #1 obs_inv |= int'(inv_mask);
      end
    end
    check("done_seen", int'(got), 1);
    check("done_onehot", obs_done, 1 << c);
    check("hit", int'(obs_hit), int'(exp_hit));
    check("inv_mask", obs_inv, exp_inv);
    check("l2_op_count", obs_ops.size(), exp_ops.size());
    for (int i = 0; i < exp_ops.size() && i < obs_ops.size(); i++)
      check($sformatf("l2_op%0d", i), obs_ops[i], exp_ops[i]);
    if (lat_chk) check("latency", cyc, 2 + 2 * exp_ops.size());
    pv[c] = 0;
    drive();
    sweep("post");
  endtask

  task automatic issue_one(input int c, input bit we, input int a);
    @(negedge clk);
    pv[c] = 1;
    pwe[c] = we;
    pad[c] = a;
    drive();
    serve(1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_hit"}, int'(hit), 0);
    check({tag, "_inv"}, int'(inv_mask), 0);
    check({tag, "_l2_en"}, int'({l2_rd_en, l2_wr_en}), 0);
    check({tag, "_l2_addr"}, int'(l2_addr), 0);
    check({tag, "_cores"}, int'({wb_core, fill_core}), 0);
  endtask

  int seq [4];
  bit saw_fill;

  initial begin
    rst = 1'b1;
    l2_ack = 1'b0;
    ack_cnt = 0;
    dbg_core = '0;
    dbg_index = '0;
    for (int i = 0; i < N; i++) begin
      pv[i] = 0; pwe[i] = 0; pad[i] = 0;
    end
    drive();
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    sweep("reset");
    rst = 1'b0;

    // 1: cold read -> single fill, exclusive
    issue_one(0, 0, 5);
    check("tp1_done", obs_done, 4'b0001);
    check("tp1_hit", int'(obs_hit), 0);
    check("tp1_ops", obs_ops.size(), 1);
    if (obs_ops.size() > 0) check("tp1_op0", obs_ops[0], enc(0, 5, 0));
    dbg_lit("tp1_dbg01", 0, 1, E_);

    // 2: second reader -> both shared
    issue_one(1, 0, 5);
    check("tp2_ops", obs_ops.size(), 1);
    if (obs_ops.size() > 0) check("tp2_op0", obs_ops[0], enc(0, 5, 1));
    dbg_lit("tp2_dbg01", 0, 1, S_);
    dbg_lit("tp2_dbg11", 1, 1, S_);

    // 3: write hit on S -> upgrade with invalidation
    issue_one(1, 1, 5);
    check("tp3_ops", obs_ops.size(), 0);
    check("tp3_inv", obs_inv, 4'b0001);
    check("tp3_done", obs_done, 4'b0010);
    check("tp3_hit", int'(obs_hit), 1);
    dbg_lit("tp3_dbg11", 1, 1, M_);
    dbg_lit("tp3_dbg01", 0, 1, I_);

    // 4: read of a line modified elsewhere -> snoop writeback then fill
    issue_one(2, 0, 5);
    check("tp4_ops", obs_ops.size(), 2);
    if (obs_ops.size() > 1) begin
      check("tp4_op0", obs_ops[0], enc(1, 5, 1));
      check("tp4_op1", obs_ops[1], enc(0, 5, 2));
    end
    dbg_lit("tp4_dbg11", 1, 1, S_);
    dbg_lit("tp4_dbg21", 2, 1, S_);

    // 5: write miss then conflicting read -> victim writeback
    issue_one(3, 1, 5);
    check("tp5_inv", obs_inv, 4'b0110);
    dbg_lit("tp5_dbg31a", 3, 1, M_);
    issue_one(3, 0, 1);
    check("tp5_ops", obs_ops.size(), 2);
    if (obs_ops.size() > 1) begin
      check("tp5_op0", obs_ops[0], enc(1, 5, 3));
      check("tp5_op1", obs_ops[1], enc(0, 1, 3));
    end
    dbg_lit("tp5_dbg31b", 3, 1, E_);

    // 6: four simultaneous read hits -> round-robin order
    issue_one(0, 0, 0);
    issue_one(1, 0, 1);
    issue_one(2, 0, 2);
    issue_one(3, 0, 1);
    @(negedge clk);
    pv = '{1, 1, 1, 1};
    pwe = '{0, 0, 0, 0};
    pad = '{0, 1, 2, 1};
    drive();
    for (int k = 0; k < 4; k++) begin
      serve(1'b0);
      seq[k] = obs_done;
      check($sformatf("tp6_hit%0d", k), int'(obs_hit), 1);
    end
    check("tp6_seq0", seq[0], 4'b0001);
    check("tp6_seq1", seq[1], 4'b0010);
    check("tp6_seq2", seq[2], 4'b0100);
    check("tp6_seq3", seq[3], 4'b1000);

    // reset during FILL aborts without a done pulse
    @(negedge clk);
    pv[0] = 1; pwe[0] = 0; pad[0] = 6;
    drive();
    saw_fill = 0;
    for (int k = 0; k < 20 && !saw_fill; k++) begin
      @(negedge clk);
      if (l2_rd_en) saw_fill = 1;
    end
    check("rst_fill_reached", int'(saw_fill), 1);
    rst = 1'b1;
    pv[0] = 0;
    drive();
    @(negedge clk);
    check_outputs_zero("midrst");
    model_reset();
    sweep("midrst");
    rst = 1'b0;
    l2_ack = 1'b0;
    ack_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("midrst_no_done", int'(done), 0);
    end

    // randomized traffic with several cores contending
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'($urandom_range(0, 1));
      pwe[i] = 1'($urandom_range(0, 1));
      pad[i] = int'($urandom_range(0, 7));
    end
    pv[0] = 1;
    drive();
    for (int t = 0; t < 300; t++) begin
      serve(1'b0);
      for (int i = 0; i < N; i++)
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1;
          pwe[i] = 1'($urandom_range(0, 1));
          pad[i] = int'($urandom_range(0, 7));
        end
      if (!(pv[0] | pv[1] | pv[2] | pv[3])) begin
        pv[t % N] = 1;
        pwe[t % N] = 1'($urandom_range(0, 1));
        pad[t % N] = int'($urandom_range(0, 7));
      end
      drive();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
